pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter WordSize, default 32, SHALL set the width of the PC, address and branch-target fields.
REQ-002 Parameter ResetVector, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 branch_taken  input  1  SHALL be the redirect request from the branch address calculator.
REQ-006 branch_addr  input  WordSize  SHALL be the redirect target, valid when branch_taken=1.
REQ-007 imem_req  output  1  SHALL be the instruction-memory request valid.
REQ-008 imem_addr  output  WordSize  SHALL be the instruction-memory request address.
REQ-009 imem_ready  input  1  SHALL indicate that memory accepts the request this cycle.
REQ-010 imem_valid  input  1  SHALL indicate a response beat on imem_rdata.
REQ-011 imem_rdata  input  32  SHALL be the response instruction word.
REQ-012 if_valid  output  1  SHALL indicate that an instruction is held for decode.
REQ-013 if_instr  output  32  SHALL be the held instruction.
REQ-014 if_pc  output  WordSize  SHALL be the fetch address of if_instr.
REQ-015 if_ready  input  1  SHALL indicate that decode consumes if_instr this cycle.
REQ-016 flush  output  1  SHALL be a one-cycle pulse requesting that younger pipeline stages be squashed.

Function
REQ-017 The block SHALL have four states: REQ, WAIT, HOLD, DISCARD.
REQ-018 At most one memory request SHALL be outstanding at any time.
REQ-019 REQ: imem_req=1 and imem_addr=pc; on imem_ready=1, the block SHALL latch req_pc<=pc, set pc<=pc+4 (modulo 2^WordSize) and go to WAIT.
REQ-020 WAIT: imem_req=0; on imem_valid=1, the block SHALL set if_instr<=imem_rdata and if_pc<=req_pc and go to HOLD.
REQ-021 HOLD: if_valid=1; on if_ready=1 the block SHALL go to REQ; otherwise if_instr and if_pc SHALL remain stable.
REQ-022 DISCARD: the block SHALL wait for the stale response; on imem_valid=1 it SHALL drop the response and go to REQ.
REQ-023 Any imem_valid received outside WAIT or DISCARD SHALL be ignored.
REQ-024 On branch_taken=1 in any state, the block SHALL set pc<={branch_addr[WordSize-1:2],2'b00}.
REQ-025 On that same edge (branch_taken=1), flush SHALL be set to 1 for exactly the next cycle.
REQ-026 Redirect in REQ without imem_ready: the block SHALL stay in REQ; the new address SHALL appear on imem_addr the next cycle.
REQ-027 Redirect in REQ with imem_ready in the same cycle: the old-address request SHALL count as issued, pc SHALL take the redirect target (not pc+4), and the state SHALL go to DISCARD.
REQ-028 Redirect in WAIT without imem_valid: the state SHALL go to DISCARD.
REQ-029 Redirect in WAIT with imem_valid in the same cycle: the response SHALL be dropped and the state SHALL go to REQ.
REQ-030 Redirect in HOLD: the held instruction SHALL be dropped and the state SHALL go to REQ, regardless of if_ready.
REQ-031 Redirect in DISCARD: pc SHALL update and the state SHALL remain DISCARD, unless imem_valid is also 1, in which case the state SHALL go to REQ.
REQ-032 Throughput SHALL be one instruction per 3 cycles minimum: accept, response, consume.
REQ-033 Latency from imem_valid to if_valid SHALL be one cycle.

Reset
REQ-034 While rst=1, the block SHALL hold: state=REQ, pc=ResetVector, req_pc=0, if_valid=0, if_instr=0, if_pc=0, flush=0.
REQ-035 Following from REQ-034, imem_req SHALL be 1 and imem_addr SHALL be ResetVector from the first cycle after rst deasserts.
REQ-036 Reset asserted mid-transaction SHALL abandon any in-flight request without waiting for its response.
REQ-037 A response arriving after reset SHALL be ignored per REQ-023.

Verification
REQ-038 Bench SHALL cover sequential fetch: after reset, with ready, valid and if_ready each asserted one cycle after the need, if_pc SHALL be 0x0, 0x4, 0x8 with matching if_instr.
REQ-039 Bench SHALL cover redirect in WAIT: request 0x10 issued, branch_taken=1 with branch_addr=0x103; then flush=1 next cycle, the 0x10 response SHALL never appear on if_valid, and the next imem_addr SHALL be 0x100.
REQ-040 Bench SHALL cover redirect coinciding with imem_ready in REQ at pc 0x20, target 0x80: the 0x20 response SHALL be discarded and the next request SHALL be 0x80.
REQ-041 Bench SHALL cover backpressure: if_ready=0 for 5 cycles in HOLD; if_instr and if_pc SHALL remain stable and no new imem_req SHALL be issued.
REQ-042 Bench SHALL cover wrap-around: with pc=0xFFFF_FFFC accepted, the next imem_addr SHALL be 0x0000_0000.
REQ-043 Bench SHALL cover mid-WAIT reset: rst pulse while waiting, then a late imem_valid; if_valid SHALL remain 0 and imem_addr SHALL equal ResetVector.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Bundle of the fetch controller's redirect, instruction-memory and decode handshakes.
// master = fetch controller side, slave = memory/decode/branch-unit side.
interface pc_fetch_if #(
    parameter int unsigned WordSize = 32
);
    localparam int unsigned InstrW = 32;

    logic                branch_taken;
    logic [WordSize-1:0] branch_addr;

    logic                imem_req;
    logic [WordSize-1:0] imem_addr;
    logic                imem_ready;
    logic                imem_valid;
    logic [InstrW-1:0]   imem_rdata;

    logic                if_valid;
    logic [InstrW-1:0]   if_instr;
    logic [WordSize-1:0] if_pc;
    logic                if_ready;

    logic                flush;

    modport master (
        input  branch_taken, branch_addr,
        input  imem_ready, imem_valid, imem_rdata,
        input  if_ready,
        output imem_req, imem_addr,
        output if_valid, if_instr, if_pc,
        output flush
    );

    modport slave (
        output branch_taken, branch_addr,
        output imem_ready, imem_valid, imem_rdata,
        output if_ready,
        input  imem_req, imem_addr,
        input  if_valid, if_instr, if_pc,
        input  flush
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: single outstanding memory request, one-entry decode
// holding register, branch redirect with stale-response discard and a one-cycle flush.
module pc_fetch_ctrl #(
    parameter int unsigned            WordSize    = 32,
    parameter logic [WordSize-1:0]    ResetVector = '0
) (
    input logic          clk,
    input logic          rst,
    pc_fetch_if.master   bus
);
    localparam int unsigned InstrW = 32;
    localparam int unsigned StepW  = 4;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    state_e              state_q,    state_d;
    logic [WordSize-1:0] pc_q,       pc_d;
    logic [WordSize-1:0] req_pc_q,   req_pc_d;
    logic [InstrW-1:0]   instr_q,    instr_d;
    logic [WordSize-1:0] if_pc_q,    if_pc_d;
    logic                if_valid_q, if_valid_d;
    logic                flush_q,    flush_d;
    logic                imem_req_q, imem_req_d;

    logic [WordSize-1:0] redirect_pc;
    logic                unused_addr_lsb;

    // Redirect targets are forced to word alignment; the dropped LSBs are intentionally unused.
    assign redirect_pc     = {bus.branch_addr[WordSize-1:2], 2'b00};
    assign unused_addr_lsb = ^bus.branch_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= ResetVector;
            req_pc_q   <= '0;
            instr_q    <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            imem_req_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            instr_q    <= instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            flush_q    <= flush_d;
            imem_req_q <= imem_req_d;
        end
    end

    // Next-state logic; a redirect overrides the sequential pc and never lets a
    // response fetched under the old path reach decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        instr_d  = instr_q;
        if_pc_d  = if_pc_q;
        flush_d  = bus.branch_taken;

        unique case (state_q)
            S_REQ: begin
                if (bus.imem_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + WordSize'(StepW);
                    state_d  = bus.branch_taken ? S_DISCARD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.branch_taken) begin
                    state_d = bus.imem_valid ? S_REQ : S_DISCARD;
                end else if (bus.imem_valid) begin
                    instr_d = bus.imem_rdata;
                    if_pc_d = req_pc_q;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.branch_taken || bus.if_ready) begin
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (bus.imem_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (bus.branch_taken) begin
            pc_d = redirect_pc;
        end

        if_valid_d = (state_d == S_HOLD);
        imem_req_d = (state_d == S_REQ);
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.flush     = flush_q;

endmodule
